// File: rtl/fifo_pkg.sv
// Shared types and elaboration helpers for the FWFT/threshold FIFO.
package fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic bit is_pow2(input int unsigned value);
    return (value != 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
module fifo_sdp_ram #(
  parameter int unsigned Depth = 128,
  parameter int unsigned Width = 8,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_fwft_thresh.sv
// Single-clock FIFO with FWFT or registered read, fill count, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow and sync flush.
module fifo_fwft_thresh
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH      = 128,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned AF_THRESH  = DEPTH - 4,
  parameter int unsigned AE_THRESH  = 4,
  parameter int unsigned FWFT       = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned AW = addr_width(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] AfLevel = CW'(AF_THRESH);
  localparam logic [CW-1:0] AeLevel = CW'(AE_THRESH);

  if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
    $error("fifo_fwft_thresh: DEPTH must be a power of two and at least 4");
  end
  if (AE_THRESH >= AF_THRESH) begin : g_bad_thresh
    $error("fifo_fwft_thresh: AE_THRESH must be below AF_THRESH");
  end

  logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [CW-1:0]         fill;
  logic                  push, pop;
  logic [DATA_WIDTH-1:0] head_data;
  fifo_status_t          status;

  // Extra MSB on each pointer distinguishes full from empty when low bits match.
  assign fill = wr_ptr_q - rd_ptr_q;

  always_comb begin
    status              = '0;
    status.empty        = (wr_ptr_q == rd_ptr_q);
    status.full         = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                          (wr_ptr_q[AW] != rd_ptr_q[AW]);
    status.almost_full  = (fill >= AfLevel);
    status.almost_empty = (fill <= AeLevel);
    status.overflow     = ovf_q;
    status.underflow    = unf_q;
  end

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
  assign pop  = rd_en & ~status.empty & ~clear;
  assign push = wr_en & (~status.full | pop) & ~clear;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + CW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + CW'(1);
      end
      if (wr_en && !push) begin
        ovf_d = 1'b1;
      end
      if (rd_en && !pop) begin
        unf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_sdp_ram #(
    .Depth (DEPTH),
    .Width (DATA_WIDTH),
    .AddrW (AW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (head_data)
  );

  if (FWFT != 0) begin : g_fwft
    // Gate the stale head entry so an empty FIFO presents zero.
    assign rd_valid = ~status.empty;
    assign rd_data  = status.empty ? '0 : head_data;
  end else begin : g_reg
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    always_comb begin
      rd_valid_d = rd_valid_q;
      rd_data_d  = rd_data_q;
      if (clear) begin
        rd_valid_d = 1'b0;
      end else begin
        rd_valid_d = pop;
        if (pop) begin
          rd_data_d = head_data;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_valid_q <= 1'b0;
        rd_data_q  <= '0;
      end else begin
        rd_valid_q <= rd_valid_d;
        rd_data_q  <= rd_data_d;
      end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
  end

  assign full         = status.full;
  assign empty        = status.empty;
  assign almost_full  = status.almost_full;
  assign almost_empty = status.almost_empty;
  assign overflow     = status.overflow;
  assign underflow    = status.underflow;
  assign count        = fill;

endmodule

// File: tb/tb_fifo_fwft_thresh.sv
// Bench for fifo_fwft_thresh: a 128-deep FWFT instance and a 16-deep registered-read instance.
module tb_fifo_fwft_thresh;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s [2];
  logic       clr_s [2];
  logic       we_s  [2];
  logic       re_s  [2];
  logic [7:0] wd_s  [2];
  logic [7:0] rdd_s [2];
  logic       rdv_s [2];
  logic       full_s[2];
  logic       empty_s[2];
  logic       af_s  [2];
  logic       ae_s  [2];
  logic       ovf_s [2];
  logic       unf_s [2];
  logic [7:0] cnt_a;
  logic [4:0] cnt_b;

  fifo_fwft_thresh u_a (
    .clk          (clk),
    .rst_n        (rst_s[0]),
    .clear        (clr_s[0]),
    .wr_en        (we_s[0]),
    .wr_data      (wd_s[0]),
    .rd_en        (re_s[0]),
    .rd_data      (rdd_s[0]),
    .rd_valid     (rdv_s[0]),
    .full         (full_s[0]),
    .empty        (empty_s[0]),
    .almost_full  (af_s[0]),
    .almost_empty (ae_s[0]),
    .count        (cnt_a),
    .overflow     (ovf_s[0]),
    .underflow    (unf_s[0])
  );

  fifo_fwft_thresh #(
    .DEPTH      (16),
    .DATA_WIDTH (8),
    .AF_THRESH  (12),
    .AE_THRESH  (2),
    .FWFT       (0)
  ) u_b (
    .clk          (clk),
    .rst_n        (rst_s[1]),
    .clear        (clr_s[1]),
    .wr_en        (we_s[1]),
    .wr_data      (wd_s[1]),
    .rd_en        (re_s[1]),
    .rd_data      (rdd_s[1]),
    .rd_valid     (rdv_s[1]),
    .full         (full_s[1]),
    .empty        (empty_s[1]),
    .almost_full  (af_s[1]),
    .almost_empty (ae_s[1]),
    .count        (cnt_b),
    .overflow     (ovf_s[1]),
    .underflow    (unf_s[1])
  );

  int total  = 0;
  int passed = 0;
  bit run    = 1'b0;

  // Reference model: circular list of stored words plus sticky flags.
  logic [7:0] mbuf [2][128];
  int         mhead[2];
  int         mcnt [2];
  bit         movf [2];
  bit         munf [2];
  bit         mrv  [2];
  logic [7:0] mrd  [2];

  function automatic int dep_of(input int i);
    return (i == 0) ? 128 : 16;
  endfunction
  function automatic int af_of(input int i);
    return (i == 0) ? 124 : 12;
  endfunction
  function automatic int ae_of(input int i);
    return (i == 0) ? 4 : 2;
  endfunction
  function automatic bit fwft_of(input int i);
    return (i == 0);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic mreset(input int i);
    mhead[i] = 0;
    mcnt[i]  = 0;
    movf[i]  = 1'b0;
    munf[i]  = 1'b0;
    mrv[i]   = 1'b0;
    mrd[i]   = 8'h00;
  endtask

  task automatic mstep(input int i);
    bit         pop, push;
    logic [7:0] v;
    if (!rst_s[i]) begin
      mreset(i);
    end else if (clr_s[i]) begin
      mhead[i] = 0;
      mcnt[i]  = 0;
      movf[i]  = 1'b0;
      munf[i]  = 1'b0;
      mrv[i]   = 1'b0;
    end else begin
      pop  = re_s[i] && (mcnt[i] > 0);
      push = we_s[i] && ((mcnt[i] < dep_of(i)) || pop);
      if (re_s[i] && !pop) munf[i] = 1'b1;
      if (we_s[i] && !push) movf[i] = 1'b1;
      mrv[i] = pop;
      if (pop) begin
        v        = mbuf[i][mhead[i]];
        mhead[i] = (mhead[i] + 1) % dep_of(i);
        mcnt[i]  = mcnt[i] - 1;
        mrd[i]   = v;
      end
      if (push) begin
        mbuf[i][(mhead[i] + mcnt[i]) % dep_of(i)] = wd_s[i];
        mcnt[i] = mcnt[i] + 1;
      end
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) mstep(i);
  end
  always @(negedge rst_s[0]) mreset(0);
  always @(negedge rst_s[1]) mreset(1);

  function automatic logic [31:0] dcnt(input int i);
    return (i == 0) ? 32'(cnt_a) : 32'(cnt_b);
  endfunction

  function automatic logic [7:0] exp_rd(input int i);
    if (fwft_of(i)) return (mcnt[i] != 0) ? mbuf[i][mhead[i]] : 8'h00;
    return mrd[i];
  endfunction

  always @(negedge clk) begin
    if (run) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("u%0d.count", i), dcnt(i), mcnt[i]);
        chk($sformatf("u%0d.full", i), full_s[i], mcnt[i] == dep_of(i));
        chk($sformatf("u%0d.empty", i), empty_s[i], mcnt[i] == 0);
        chk($sformatf("u%0d.almost_full", i), af_s[i], mcnt[i] >= af_of(i));
        chk($sformatf("u%0d.almost_empty", i), ae_s[i], mcnt[i] <= ae_of(i));
        chk($sformatf("u%0d.overflow", i), ovf_s[i], movf[i]);
        chk($sformatf("u%0d.underflow", i), unf_s[i], munf[i]);
        chk($sformatf("u%0d.rd_valid", i), rdv_s[i], fwft_of(i) ? (mcnt[i] != 0) : mrv[i]);
        chk($sformatf("u%0d.rd_data", i), rdd_s[i], exp_rd(i));
      end
    end
  end

  task automatic cyc(input int i, input bit c, input bit w, input logic [7:0] d, input bit r);
    clr_s[i] = c;
    we_s[i]  = w;
    wd_s[i]  = d;
    re_s[i]  = r;
    @(posedge clk);
    #1;
    clr_s[i] = 1'b0;
    we_s[i]  = 1'b0;
    re_s[i]  = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_s[i] = 1'b1;
      clr_s[i] = 1'b0;
      we_s[i]  = 1'b0;
      re_s[i]  = 1'b0;
      wd_s[i]  = 8'h00;
      mreset(i);
    end
    #1;
    rst_s[0] = 1'b0;
    rst_s[1] = 1'b0;
    #2;
    run = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset count a", cnt_a, 0);
    chk("reset empty a", empty_s[0], 1);
    chk("reset almost_empty a", ae_s[0], 1);
    chk("reset rd_valid b", rdv_s[1], 0);
    rst_s[0] = 1'b1;
    rst_s[1] = 1'b1;

    // FWFT ordering: 8 pushes then 8 pops
    for (int k = 1; k <= 8; k++) cyc(0, 0, 1, 8'(k), 0);
    chk("a count after 8 pushes", cnt_a, 8);
    for (int k = 1; k <= 8; k++) begin
      chk("a fwft head", rdd_s[0], k);
      cyc(0, 0, 0, 8'h00, 1);
    end
    chk("a count after drain", cnt_a, 0);
    chk("a empty after drain", empty_s[0], 1);

    // Fill to full, overflow, first-word check
    for (int k = 0; k < 128; k++) cyc(0, 0, 1, 8'(k), 0);
    chk("a full at 128", full_s[0], 1);
    chk("a count 128", cnt_a, 128);
    cyc(0, 0, 1, 8'hFF, 0);
    chk("a overflow on 129th", ovf_s[0], 1);
    chk("a count held 128", cnt_a, 128);
    chk("a first word", rdd_s[0], 8'h00);
    cyc(0, 0, 0, 8'h00, 1);
    chk("a full after pop", full_s[0], 0);
    chk("a next head", rdd_s[0], 8'h01);

    // Clear, refill, simultaneous push+pop while full
    cyc(0, 1, 0, 8'h00, 0);
    chk("a overflow cleared", ovf_s[0], 0);
    chk("a count cleared", cnt_a, 0);
    for (int k = 0; k < 128; k++) cyc(0, 0, 1, 8'(k), 0);
    for (int k = 0; k < 10; k++) begin
      chk("a full rw head", rdd_s[0], k);
      cyc(0, 0, 1, 8'(8'h80 + k), 1);
      chk("a full rw count", cnt_a, 128);
    end
    chk("a no overflow on full rw", ovf_s[0], 0);

    // Underflow and clear; empty write+read
    cyc(0, 1, 0, 8'h00, 0);
    cyc(0, 0, 0, 8'h00, 1);
    chk("a underflow", unf_s[0], 1);
    chk("a count 0 on underflow", cnt_a, 0);
    cyc(0, 1, 0, 8'h00, 0);
    chk("a underflow cleared", unf_s[0], 0);
    cyc(0, 0, 1, 8'h3C, 1);
    chk("a empty rw underflow", unf_s[0], 1);
    chk("a empty rw count", cnt_a, 1);
    chk("a empty rw data", rdd_s[0], 8'h3C);

    // Registered read mode
    cyc(1, 0, 1, 8'hA5, 0);
    cyc(1, 0, 0, 8'h00, 1);
    chk("b rd_valid after pop", rdv_s[1], 1);
    chk("b rd_data after pop", rdd_s[1], 8'hA5);
    cyc(1, 0, 0, 8'h00, 0);
    chk("b rd_valid drops", rdv_s[1], 0);
    chk("b rd_data holds", rdd_s[1], 8'hA5);

    // Threshold edges on the 16-deep instance
    for (int k = 1; k <= 12; k++) begin
      cyc(1, 0, 1, 8'(8'h40 + k), 0);
      chk("b almost_full edge", af_s[1], k >= 12);
    end
    for (int n = 11; n >= 2; n--) begin
      cyc(1, 0, 0, 8'h00, 1);
      chk("b almost_empty edge", ae_s[1], n <= 2);
      chk("b drain data", rdd_s[1], 8'(8'h40 + 12 - n));
    end

    // Asynchronous reset mid-stream
    cyc(1, 0, 1, 8'h77, 1);
    #2;
    rst_s[1] = 1'b0;
    #1;
    chk("b reset count", cnt_b, 0);
    chk("b reset empty", empty_s[1], 1);
    chk("b reset almost_empty", ae_s[1], 1);
    chk("b reset rd_valid", rdv_s[1], 0);
    chk("b reset rd_data", rdd_s[1], 8'h00);
    @(posedge clk);
    #1;
    rst_s[1] = 1'b1;
    cyc(1, 0, 1, 8'h11, 0);
    cyc(1, 0, 0, 8'h00, 1);
    chk("b data after reset", rdd_s[1], 8'h11);

    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
